l2_arbiter: RTL and testbench

Shares the single L2 controller between the L1 instruction cache (port I, read-only) and the L1 data cache (port D, read/write). It sits between both L1 controllers and the L2 controller's request inputs (tag/index/read/write) and ready output. It holds one grant until L2 completes the access, then routes the ready pulse back to the winner. Arbitration is round-robin unless fixed priority is compiled in.

---
 rtl/l2_arbiter_if.sv | 45 ++++
 rtl/l2_arbiter.sv | 158 +++++++++++++++
 tb/tb_l2_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if
//   Bundles the L1I/L1D request side, the L2 request side and the L2 ready
//   handshake seen by the L2 arbiter.
//   Modports:
//     slave  - arbiter view: L1 requests, flush and L2 ready in;
//              L2 request, routed readies and busy out.
//     master - environment view (L1 controllers, L2 controller): opposite directions.
interface l2_arbiter_if #(
  parameter int TNUM = 18,
  parameter int INUM = 26 - TNUM
);
  logic            read_L1I_L2;
  logic [TNUM-1:0] tag_L1I_L2;
  logic [INUM-1:0] index_L1I_L2;
  logic            read_L1D_L2;
  logic            write_L1D_L2;
  logic [TNUM-1:0] tag_L1D_L2;
  logic [INUM-1:0] index_L1D_L2;
  logic            flush;
  logic            ready_L2_L1;

  logic            read_L1_L2;
  logic            write_L1_L2;
  logic [TNUM-1:0] tag_L1_L2;
  logic [INUM-1:0] index_L1_L2;
  logic            ready_L2_L1I;
  logic            ready_L2_L1D;
  logic            busy;

  modport slave (
    input  read_L1I_L2, tag_L1I_L2, index_L1I_L2,
    input  read_L1D_L2, write_L1D_L2, tag_L1D_L2, index_L1D_L2,
    input  flush, ready_L2_L1,
    output read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2,
    output ready_L2_L1I, ready_L2_L1D, busy
  );

  modport master (
    output read_L1I_L2, tag_L1I_L2, index_L1I_L2,
    output read_L1D_L2, write_L1D_L2, tag_L1D_L2, index_L1D_L2,
    output flush, ready_L2_L1,
    input  read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2,
    input  ready_L2_L1I, ready_L2_L1D, busy
  );
endinterface

// File: rtl/l2_arbiter.sv
// l2_arbiter
//   Shares one L2 controller between the L1 instruction cache (read only) and
//   the L1 data cache (read/write). One grant is held until L2 pulses ready;
//   the ready is routed back combinationally to the granted side, then one
//   RELEASE cycle with the request lines low precedes the next grant.
//   Ports:
//     clk   - clock
//     nrst  - asynchronous active-low reset
//     bus   - l2_arbiter_if.slave (L1 requests, flush, L2 request/ready, busy)
//   Build option:
//     L2_ARB_FIXED_PRIO_EN - D always wins ties (no last_grant state);
//                            undefined gives round-robin arbitration.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no access; arbitrate when flush is low
//   GNT_I   | I-side access issued to L2, waiting for ready_L2_L1
//   GNT_D   | D-side access issued to L2, waiting for ready_L2_L1
//   RELEASE | one cycle with read/write low so L2 sees a fresh request edge
module l2_arbiter #(
  parameter int TNUM = 18,
  parameter int INUM = 26 - TNUM
) (
  input logic         clk,
  input logic         nrst,
  l2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;

  state_t          state_q, state_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic            busy_q, busy_d;
  logic [TNUM-1:0] tag_q, tag_d;
  logic [INUM-1:0] index_q, index_d;

  logic req_i, req_d;
  logic win_i, win_d;

`ifndef L2_ARB_FIXED_PRIO_EN
  // 1 = D was granted last, so I wins the next tie
  logic last_d_q, last_d_d;
`endif

  always_comb begin
    req_i = bus.read_L1I_L2;
    req_d = bus.read_L1D_L2 | bus.write_L1D_L2;
`ifdef L2_ARB_FIXED_PRIO_EN
    win_d = req_d;
    win_i = req_i & ~req_d;
`else
    win_i = req_i & (~req_d | last_d_q);
    win_d = req_d & ~win_i;
`endif
  end

  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    write_d  = write_q;
    busy_d   = busy_q;
    tag_d    = tag_q;
    index_d  = index_q;
`ifndef L2_ARB_FIXED_PRIO_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.flush) begin
          if (win_i) begin
            state_d  = GNT_I;
            read_d   = 1'b1;
            write_d  = 1'b0;
            busy_d   = 1'b1;
            tag_d    = bus.tag_L1I_L2;
            index_d  = bus.index_L1I_L2;
`ifndef L2_ARB_FIXED_PRIO_EN
            last_d_d = 1'b0;
`endif
          end else if (win_d) begin
            state_d  = GNT_D;
            // a simultaneous read+write forwards only the write
            read_d   = bus.read_L1D_L2 & ~bus.write_L1D_L2;
            write_d  = bus.write_L1D_L2;
            busy_d   = 1'b1;
            tag_d    = bus.tag_L1D_L2;
            index_d  = bus.index_L1D_L2;
`ifndef L2_ARB_FIXED_PRIO_EN
            last_d_d = 1'b1;
`endif
          end
        end
      end
      GNT_I, GNT_D: begin
        if (bus.ready_L2_L1) begin
          state_d = RELEASE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      tag_q    <= '0;
      index_q  <= '0;
`ifndef L2_ARB_FIXED_PRIO_EN
      last_d_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
`ifndef L2_ARB_FIXED_PRIO_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  assign bus.read_L1_L2   = read_q;
  assign bus.write_L1_L2  = write_q;
  assign bus.tag_L1_L2    = tag_q;
  assign bus.index_L1_L2  = index_q;
  assign bus.busy         = busy_q;
  // ready is returned in the same cycle L2 raises it
  assign bus.ready_L2_L1I = (state_q == GNT_I) & bus.ready_L2_L1;
  assign bus.ready_L2_L1D = (state_q == GNT_D) & bus.ready_L2_L1;

`ifndef SYNTHESIS
  // flag a D-side grant carrying read and write together
  always @(posedge clk) begin
    if (nrst && state_q == IDLE && !bus.flush && win_d) begin
      d_rw_exclusive: assert (!(bus.read_L1D_L2 && bus.write_L1D_L2))
        else $warning("l2_arbiter: D read and write both high, forwarding write only");
    end
  end
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;
  localparam int TNUM = 18;
  localparam int INUM = 26 - TNUM;

  logic clk;
  logic nrst;
  int   total = 0;
  int   bad   = 0;

  l2_arbiter_if #(.TNUM(TNUM), .INUM(INUM)) bus_if ();

  l2_arbiter #(.TNUM(TNUM), .INUM(INUM)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 none, 1 I, 2 D. rel marks the one quiet cycle after a completion.
  int              m_owner;
  bit              m_rel;
  bit              m_last_d;
  bit              m_rd, m_wr;
  logic [TNUM-1:0] m_tag;
  logic [INUM-1:0] m_idx;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_owner = 0; m_rel = 0; m_last_d = 1; m_rd = 0; m_wr = 0; m_tag = '0; m_idx = '0;
    end else if (m_owner != 0) begin
      if (bus_if.ready_L2_L1) begin
        m_owner = 0; m_rel = 1; m_rd = 0; m_wr = 0;
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else if (!bus_if.flush) begin
      bit ri, rd;
      int pick;
      ri = bus_if.read_L1I_L2;
      rd = bus_if.read_L1D_L2 | bus_if.write_L1D_L2;
      pick = 0;
`ifdef L2_ARB_FIXED_PRIO_EN
      if (rd) pick = 2; else if (ri) pick = 1;
`else
      if (ri && rd) pick = m_last_d ? 1 : 2;
      else if (ri)  pick = 1;
      else if (rd)  pick = 2;
`endif
      if (pick == 1) begin
        m_owner = 1; m_rd = 1; m_wr = 0; m_last_d = 0;
        m_tag = bus_if.tag_L1I_L2; m_idx = bus_if.index_L1I_L2;
      end else if (pick == 2) begin
        m_owner = 2; m_last_d = 1;
        m_wr = bus_if.write_L1D_L2;
        m_rd = bus_if.read_L1D_L2 & ~bus_if.write_L1D_L2;
        m_tag = bus_if.tag_L1D_L2; m_idx = bus_if.index_L1D_L2;
      end
    end
  end

  always @(negedge clk) begin
    check("m_read",   32'(bus_if.read_L1_L2),   32'(m_rd));
    check("m_write",  32'(bus_if.write_L1_L2),  32'(m_wr));
    check("m_tag",    32'(bus_if.tag_L1_L2),    32'(m_tag));
    check("m_index",  32'(bus_if.index_L1_L2),  32'(m_idx));
    check("m_busy",   32'(bus_if.busy),         32'(m_owner != 0 || m_rel));
    check("m_readyI", 32'(bus_if.ready_L2_L1I), 32'(m_owner == 1 && bus_if.ready_L2_L1));
    check("m_readyD", 32'(bus_if.ready_L2_L1D), 32'(m_owner == 2 && bus_if.ready_L2_L1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!(bus_if.read_L1_L2 | bus_if.write_L1_L2) && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL grant_wait: no L2 request within %0d cycles", n);
    end
  endtask

  // pulse L2 ready for one cycle; who = {ready_L2_L1D, ready_L2_L1I} seen during it
  task automatic serve(output logic [1:0] who);
    wait_grant();
    bus_if.ready_L2_L1 = 1'b1;
    #2;
    who = {bus_if.ready_L2_L1D, bus_if.ready_L2_L1I};
    step();
    bus_if.ready_L2_L1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] who;
    logic [1:0] order [4];
    logic [1:0] exp_order [4];

    nrst = 1'b0;
    bus_if.read_L1I_L2 = 0; bus_if.tag_L1I_L2 = '0; bus_if.index_L1I_L2 = '0;
    bus_if.read_L1D_L2 = 0; bus_if.write_L1D_L2 = 0;
    bus_if.tag_L1D_L2 = '0; bus_if.index_L1D_L2 = '0;
    bus_if.flush = 0; bus_if.ready_L2_L1 = 0;
    step();
    step();
    nrst = 1'b1;
    step();

    // reset state
    check("rst_read",  32'(bus_if.read_L1_L2),  0);
    check("rst_write", 32'(bus_if.write_L1_L2), 0);
    check("rst_tag",   32'(bus_if.tag_L1_L2),   0);
    check("rst_busy",  32'(bus_if.busy),        0);

    // single I read
    bus_if.read_L1I_L2 = 1; bus_if.tag_L1I_L2 = 18'h2A5A5; bus_if.index_L1I_L2 = 8'h3C;
    step();
    check("i_read",  32'(bus_if.read_L1_L2),  1);
    check("i_tag",   32'(bus_if.tag_L1_L2),   32'h2A5A5);
    check("i_index", 32'(bus_if.index_L1_L2), 32'h3C);
    check("i_busy",  32'(bus_if.busy),        1);
    serve(who);
    check("i_ready_route", 32'(who), 32'b01);
    bus_if.read_L1I_L2 = 0;
    check("i_release_read", 32'(bus_if.read_L1_L2), 0);
    check("i_release_busy", 32'(bus_if.busy),       1);
    step();
    step();

    // simultaneous continuous I and D reads
    do_reset();
    bus_if.read_L1I_L2 = 1; bus_if.tag_L1I_L2 = 18'h00111; bus_if.index_L1I_L2 = 8'h11;
    bus_if.read_L1D_L2 = 1; bus_if.tag_L1D_L2 = 18'h00222; bus_if.index_L1D_L2 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      serve(who);
      order[k] = who;
    end
    bus_if.read_L1I_L2 = 0; bus_if.read_L1D_L2 = 0;
`ifdef L2_ARB_FIXED_PRIO_EN
    exp_order = '{2'b10, 2'b10, 2'b10, 2'b10};
`else
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int k = 0; k < 4; k++) check($sformatf("tie_order_%0d", k), 32'(order[k]), 32'(exp_order[k]));
    step();
    step();

    // D write, address changes mid-grant
    bus_if.write_L1D_L2 = 1; bus_if.tag_L1D_L2 = 18'h3FFFF; bus_if.index_L1D_L2 = 8'h10;
    wait_grant();
    bus_if.index_L1D_L2 = 8'h20; bus_if.tag_L1D_L2 = 18'h00001;
    step();
    step();
    check("dw_index_hold", 32'(bus_if.index_L1_L2), 32'h10);
    check("dw_tag_hold",   32'(bus_if.tag_L1_L2),   32'h3FFFF);
    check("dw_write",      32'(bus_if.write_L1_L2), 1);
    serve(who);
    check("dw_ready_route", 32'(who), 32'b10);
    bus_if.write_L1D_L2 = 0;
    step();
    step();

    // flush blocks a new grant
    bus_if.flush = 1; bus_if.read_L1I_L2 = 1; bus_if.tag_L1I_L2 = 18'h12345; bus_if.index_L1I_L2 = 8'h5A;
    step(); step(); step();
    check("flush_no_read", 32'(bus_if.read_L1_L2), 0);
    check("flush_no_busy", 32'(bus_if.busy),       0);
    bus_if.flush = 0;
    step();
    check("flush_fall_grant", 32'(bus_if.read_L1_L2), 1);
    serve(who);
    bus_if.read_L1I_L2 = 0;
    // flush raised during a D grant does not abort it
    bus_if.read_L1D_L2 = 1; bus_if.tag_L1D_L2 = 18'h0ABCD; bus_if.index_L1D_L2 = 8'h77;
    wait_grant();
    bus_if.flush = 1;
    step();
    step();
    check("flush_d_held", 32'(bus_if.read_L1_L2), 1);
    serve(who);
    check("flush_d_done", 32'(who), 32'b10);
    bus_if.flush = 0; bus_if.read_L1D_L2 = 0;
    step();
    step();

    // D read and write together: write only
    bus_if.read_L1D_L2 = 1; bus_if.write_L1D_L2 = 1; bus_if.index_L1D_L2 = 8'h42;
    wait_grant();
    check("rw_write", 32'(bus_if.write_L1_L2), 1);
    check("rw_read",  32'(bus_if.read_L1_L2),  0);
    serve(who);
    bus_if.read_L1D_L2 = 0; bus_if.write_L1D_L2 = 0;
    step();
    step();

    // reset during an I grant
    bus_if.read_L1I_L2 = 1; bus_if.tag_L1I_L2 = 18'h2A5A5; bus_if.index_L1I_L2 = 8'h3C;
    wait_grant();
    nrst = 1'b0;
    #1;
    check("mid_rst_read",  32'(bus_if.read_L1_L2),  0);
    check("mid_rst_tag",   32'(bus_if.tag_L1_L2),   0);
    check("mid_rst_index", 32'(bus_if.index_L1_L2), 0);
    check("mid_rst_busy",  32'(bus_if.busy),        0);
    bus_if.read_L1I_L2 = 0;
    step();
    nrst = 1'b1;
    step();
    bus_if.ready_L2_L1 = 1;
    #1;
    check("late_ready_I", 32'(bus_if.ready_L2_L1I), 0);
    check("late_ready_D", 32'(bus_if.ready_L2_L1D), 0);
    step();
    bus_if.ready_L2_L1 = 0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
